// File: rtl/mux_i4_1.sv
// Four-way WIDTH-bit selector with a combinational output plus registered copies of output and select.
// Optional MUX_I4_1_ONEHOT_EN adds sel_oh, a one-hot decode of the registered select.
module mux_i4_1 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       s,
  input  logic             en,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q,
  output logic [1:0]       s_q,
`ifdef MUX_I4_1_ONEHOT_EN
  output logic             o_vld,
  output logic [3:0]       sel_oh
`else
  output logic             o_vld
`endif
);

  logic [WIDTH-1:0] o_p0;
  logic [WIDTH-1:0] o_p1;
  logic [1:0]       s_p1;
  logic             vld_p1;

  // Stage p0: combinational select; an unknown select poisons the output in simulation
  always_comb begin
    o_p0 = 'x;
    case (s)
      2'b00:   o_p0 = i0;
      2'b01:   o_p0 = i1;
      2'b10:   o_p0 = i2;
      2'b11:   o_p0 = i3;
      default: o_p0 = 'x;
    endcase
  end

  assign o = o_p0;

  // Stage p1: enabled capture of the selected data and select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_p1   <= '0;
      s_p1   <= 2'b00;
      vld_p1 <= 1'b0;
    end else if (en) begin
      o_p1   <= o_p0;
      s_p1   <= s;
      vld_p1 <= 1'b1;
    end
  end

  assign o_q   = o_p1;
  assign s_q   = s_p1;
  assign o_vld = vld_p1;

`ifdef MUX_I4_1_ONEHOT_EN
  always_comb begin
    sel_oh = 4'b0000;
    if (vld_p1) sel_oh[s_p1] = 1'b1;
  end
`endif

endmodule

// File: tb/tb_mux_i4_1.sv
// Scoreboard bench for mux_i4_1: stimulus queues hand-computed expectations, a monitor compares them.
module tb_mux_i4_1;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] i0, i1, i2, i3;
  logic [1:0]   s;
  logic         en;
  logic [W-1:0] o, o_q;
  logic [1:0]   s_q;
  logic         o_vld;
`ifdef MUX_I4_1_ONEHOT_EN
  logic [3:0]   sel_oh;
`endif

  mux_i4_1 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .s(s), .en(en),
    .o(o), .o_q(o_q), .s_q(s_q),
`ifdef MUX_I4_1_ONEHOT_EN
    .o_vld(o_vld), .sel_oh(sel_oh)
`else
    .o_vld(o_vld)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] o;
    logic [W-1:0] o_q;
    logic [1:0]   s_q;
    logic         vld;
    logic [3:0]   oh;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   total = 0;
  int   bad = 0;

  task automatic expect_out(input string name, input logic [W-1:0] eo,
                            input logic [W-1:0] eoq, input logic [1:0] esq,
                            input logic evld, input logic [3:0] eoh);
    exp_t e;
    e.name = name; e.o = eo; e.o_q = eoq; e.s_q = esq; e.vld = evld; e.oh = eoh;
    sb.push_back(e);
    -> chk_ev;
  endtask

  // Monitor: pops every queued expectation at each sample strobe
  initial begin
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        exp_t e;
        logic [3:0] act_oh;
        e = sb.pop_front();
`ifdef MUX_I4_1_ONEHOT_EN
        act_oh = sel_oh;
`else
        act_oh = e.oh;
`endif
        total++;
        if ({o, o_q, s_q, o_vld, act_oh} !== {e.o, e.o_q, e.s_q, e.vld, e.oh}) begin
          bad++;
          $display("FAIL %s: got o=%b o_q=%b s_q=%b o_vld=%b oh=%b, want o=%b o_q=%b s_q=%b o_vld=%b oh=%b",
                   e.name, o, o_q, s_q, o_vld, act_oh, e.o, e.o_q, e.s_q, e.vld, e.oh);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want test completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic edge_sample();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; s = 2'b00;
    i0 = 2'b00; i1 = 2'b01; i2 = 2'b10; i3 = 2'b11;
    #3;

    // Combinational sweep with reset held low (and en high across edges)
    s = 2'b00; #2; expect_out("rst_sweep_s00", 2'b00, 2'b00, 2'b00, 1'b0, 4'b0000); #8;
    s = 2'b01; #2; expect_out("rst_sweep_s01", 2'b01, 2'b00, 2'b00, 1'b0, 4'b0000); #8;
    s = 2'b10; #2; expect_out("rst_sweep_s10", 2'b10, 2'b00, 2'b00, 1'b0, 4'b0000); #8;
    s = 2'b11; #2; expect_out("rst_sweep_s11", 2'b11, 2'b00, 2'b00, 1'b0, 4'b0000); #8;

    // Release and first load
    @(negedge clk); rst_n = 1'b1; en = 1'b1; s = 2'b10;
    edge_sample();
    expect_out("first_load", 2'b10, 2'b10, 2'b10, 1'b1, 4'b0100);

    // Hold with en low
    @(negedge clk); en = 1'b0; s = 2'b01;
    #1; expect_out("hold_pre_edge", 2'b01, 2'b10, 2'b10, 1'b1, 4'b0100);
    edge_sample();
    expect_out("hold_post_edge", 2'b01, 2'b10, 2'b10, 1'b1, 4'b0100);

    // Asynchronous reset between edges
    @(negedge clk); #2; rst_n = 1'b0;
    #1; expect_out("async_reset", 2'b01, 2'b00, 2'b00, 1'b0, 4'b0000);

    // Reload after reset release
    @(negedge clk); rst_n = 1'b1; en = 1'b1; s = 2'b11;
    edge_sample();
    expect_out("reload_s11", 2'b11, 2'b11, 2'b11, 1'b1, 4'b1000);

    // Data change on the selected input: o moves now, o_q only on an enabled edge
    @(negedge clk); en = 1'b0; i3 = 2'b00;
    #1; expect_out("i3_change_comb", 2'b00, 2'b11, 2'b11, 1'b1, 4'b1000);
    edge_sample();
    expect_out("i3_change_held", 2'b00, 2'b11, 2'b11, 1'b1, 4'b1000);
    @(negedge clk); en = 1'b1;
    edge_sample();
    expect_out("i3_change_load", 2'b00, 2'b00, 2'b11, 1'b1, 4'b1000);
    @(negedge clk); i3 = 2'b11;

    // Load sweep through all selects
    s = 2'b00; edge_sample(); expect_out("load_s00", 2'b00, 2'b00, 2'b00, 1'b1, 4'b0001);
    @(negedge clk); s = 2'b01; edge_sample(); expect_out("load_s01", 2'b01, 2'b01, 2'b01, 1'b1, 4'b0010);
    @(negedge clk); s = 2'b10; edge_sample(); expect_out("load_s10", 2'b10, 2'b10, 2'b10, 1'b1, 4'b0100);
    @(negedge clk); s = 2'b11; edge_sample(); expect_out("load_s11", 2'b11, 2'b11, 2'b11, 1'b1, 4'b1000);

    // Final reset clears everything including the one-hot decode
    @(negedge clk); #2; rst_n = 1'b0;
    #1; expect_out("final_reset", 2'b11, 2'b00, 2'b00, 1'b0, 4'b0000);
    edge_sample();
    expect_out("reset_held_edge", 2'b11, 2'b00, 2'b00, 1'b0, 4'b0000);

    #2;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
